// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and weight-address helper for the hidden-layer datapath.
`default_nettype none

package nn_pkg;

    localparam int X_W = 4;
    localparam int W_W = 8;
    localparam int R_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] k;
        logic [7:0] j;
    } waddr_t;

    // Flat weight address k*X_W + j split back into neuron k and input j.
    function automatic waddr_t split_waddr(input logic [7:0] addr);
        waddr_t s;
        s.k = addr / 8'(X_W);
        s.j = addr % 8'(X_W);
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hidden_neuron.sv
// Shared hidden neuron: registered signed sum of the weights whose input bit is set.
`default_nettype none

module hidden_neuron
    import nn_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [X_W-1:0]       x_i,
    input  logic [X_W*W_W-1:0]   w_i,
    output logic [R_W-1:0]       result_o
);

    logic [R_W-1:0] sum_d;
    logic [R_W-1:0] result_q;

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < X_W; j++) begin
            if (x_i[j]) begin
                sum_d = sum_d + R_W'($signed(w_i[j*W_W +: W_W]));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
        end else if (en_i) begin
            result_q <= sum_d;
        end
    end

    assign result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/hidden_weight_bank.sv
// Per-neuron weight register file: synchronous write, combinational read of one neuron's weights.
`default_nettype none

module hidden_weight_bank
    import nn_pkg::*;
#(
    parameter  int NUM_HIDDEN = 4,
    localparam int DEPTH      = NUM_HIDDEN * X_W,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int KW         = $clog2(NUM_HIDDEN),
    localparam int JW         = $clog2(X_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_addr_i,
    input  logic [W_W-1:0]       wr_data_i,
    input  logic [KW-1:0]        rd_k_i,
    output logic [X_W*W_W-1:0]   rd_w_o
);

    logic [W_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar j = 0; j < X_W; j++) begin : g_rd
        localparam logic [JW-1:0] J_IDX = JW'(j);
        assign rd_w_o[j*W_W +: W_W] = mem_q[{rd_k_i, J_IDX}];
    end

endmodule

`default_nettype wire

// File: rtl/hidden_layer_sequencer.sv
// Time-multiplexes one shared hidden neuron over NUM_HIDDEN logical neurons and
// presents the collected layer results as one packed word.
`default_nettype none

module hidden_layer_sequencer
    import nn_pkg::*;
#(
    parameter  int NUM_HIDDEN = 4,
    localparam int DEPTH      = NUM_HIDDEN * X_W,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int KW         = $clog2(NUM_HIDDEN),
    // one spare bit so that addresses past the bank are representable and rejected
    localparam int ADDR_W     = IDX_W + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      x_valid_i,
    output logic                      x_ready_o,
    input  logic [X_W-1:0]            x_i,
    input  logic                      wr_en_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [W_W-1:0]            wr_data_i,
    output logic                      wr_err_o,
    output logic                      neuron_en_o,
    output logic [X_W-1:0]            neuron_x_o,
    output logic [X_W*W_W-1:0]        neuron_w_o,
    input  logic [R_W-1:0]            neuron_result_i,
    output logic                      hidden_valid_o,
    input  logic                      hidden_ready_i,
    output logic [NUM_HIDDEN*R_W-1:0] hidden_o,
    output logic                      busy_o
);

    state_e                    state_q;
    logic [KW-1:0]             k_q;
    logic [X_W-1:0]            x_q;
    logic [X_W*W_W-1:0]        w_q;
    logic [NUM_HIDDEN*R_W-1:0] slots_q;
    logic                      wr_err_q;

    logic                      wr_ok;
    waddr_t                    wr_split;
    logic [KW-1:0]             rd_k;
    logic [X_W*W_W-1:0]        rd_w;
    logic [X_W*W_W-1:0]        w_d;

    assign wr_ok    = wr_en_i && (state_q == IDLE) && (wr_addr_i < ADDR_W'(DEPTH));
    assign wr_split = split_waddr(8'(wr_addr_i));
    assign rd_k     = (state_q == IDLE) ? '0 : k_q + 1'b1;

    hidden_weight_bank #(
        .NUM_HIDDEN (NUM_HIDDEN)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr_i[IDX_W-1:0]),
        .wr_data_i (wr_data_i),
        .rd_k_i    (rd_k),
        .rd_w_o    (rd_w)
    );

    // A write landing on the same edge as the accept must reach the first DRIVE.
    always_comb begin
        w_d = rd_w;
        for (int j = 0; j < X_W; j++) begin
            if (wr_ok && (wr_split.k == 8'(rd_k)) && (wr_split.j == 8'(j))) begin
                w_d[j*W_W +: W_W] = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            x_q      <= '0;
            w_q      <= '0;
            slots_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en_i && !wr_ok;
            case (state_q)
                IDLE: begin
                    if (x_valid_i) begin
                        x_q     <= x_i;
                        k_q     <= '0;
                        w_q     <= w_d;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    slots_q[int'(k_q)*R_W +: R_W] <= neuron_result_i;
                    if (k_q == KW'(NUM_HIDDEN - 1)) begin
                        state_q <= OUTPUT;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        w_q     <= w_d;
                        state_q <= DRIVE;
                    end
                end
                OUTPUT: begin
                    if (hidden_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign x_ready_o      = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign neuron_en_o    = (state_q == DRIVE);
    assign hidden_valid_o = (state_q == OUTPUT);
    assign neuron_x_o     = x_q;
    assign neuron_w_o     = w_q;
    assign hidden_o       = slots_q;
    assign wr_err_o       = wr_err_q;

endmodule

`default_nettype wire
